// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the zhxpu fetch stage.
// Bus widths, FSM encodings and the IF/ID bundle.
package inst_fetch_unit_pkg;

  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] reg_value_t;

  localparam reg_value_t NOP_INST_DEF = 16'h0800;
  localparam reg_value_t RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HELD  = 2'd2
  } state_e;

  typedef struct packed {
    reg_value_t pc;
    reg_value_t inst;
    logic       valid;
  } if_id_t;

endpackage

// File: rtl/inst_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Bubble wins over load; neither asserted means hold.
module if_id_reg
  import inst_fetch_unit_pkg::*;
#(
  parameter reg_value_t NOP_INST = NOP_INST_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       bubble_i,
  input  reg_value_t pc_i,
  input  reg_value_t inst_i,
  output if_id_t     q_o
);

  if_id_t q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    end else if (bubble_i) begin
      q_q <= '{pc: pc_i, inst: NOP_INST, valid: 1'b0};
    end else if (load_i) begin
      q_q <= '{pc: pc_i, inst: inst_i, valid: 1'b1};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// zhxpu fetch stage: PC, wait/stall/branch FSM and
// a one-entry hold buffer so stalled words are not re-read.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter reg_value_t RESET_PC = RESET_PC_DEF,
  parameter reg_value_t NOP_INST = NOP_INST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output reg_value_t inst_addr,
  input  reg_value_t inst_data,
  input  logic       inst_done,
  input  logic       id_stall,
  input  logic       branch_taken,
  input  reg_value_t branch_target,
  output reg_value_t if_id_pc,
  output reg_value_t if_id_inst,
  output logic       if_id_valid,
  output logic       fetch_busy
);

  state_e     state_q, state_d;
  reg_value_t pc_q, pc_d;
  reg_value_t hold_inst_q, hold_inst_d;
  reg_value_t hold_pc_q, hold_pc_d;

  logic       ifid_load;
  logic       ifid_bubble;
  reg_value_t ifid_pc;
  reg_value_t ifid_inst;
  if_id_t     ifid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      hold_inst_q <= NOP_INST;
      hold_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_pc     = pc_q;
    ifid_inst   = inst_data;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (branch_taken && !id_stall) begin
          pc_d        = branch_target;
          ifid_bubble = 1'b1;
          ifid_pc     = branch_target;
        end else if (id_stall) begin
          if (inst_done) begin
            hold_inst_d = inst_data;
            hold_pc_d   = pc_q;
            state_d     = S_HELD;
          end
        end else if (inst_done) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 16'd1;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
      S_HELD: begin
        if (branch_taken && !id_stall) begin
          pc_d        = branch_target;
          ifid_bubble = 1'b1;
          ifid_pc     = branch_target;
          state_d     = S_FETCH;
        end else if (!id_stall) begin
          ifid_load = 1'b1;
          ifid_pc   = hold_pc_q;
          ifid_inst = hold_inst_q;
          pc_d      = pc_q + 16'd1;
          state_d   = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .pc_i     (ifid_pc),
    .inst_i   (ifid_inst),
    .q_o      (ifid_q)
  );

  assign inst_addr   = pc_q;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_inst  = ifid_q.inst;
  assign if_id_valid = ifid_q.valid;
  assign fetch_busy  = (state_q == S_FETCH) && !inst_done;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed scoreboard bench for inst_fetch_unit.
// Memory model answers addr ^ 16'h1000.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] inst_addr;
  logic [15:0] inst_data;
  logic        inst_done;
  logic        id_stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_inst;
  logic        if_id_valid;
  logic        fetch_busy;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
    logic        v;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .inst_addr     (inst_addr),
    .inst_data     (inst_data),
    .inst_done     (inst_done),
    .id_stall      (id_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid),
    .fetch_busy    (fetch_busy)
  );

  assign inst_data = inst_addr ^ 16'h1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag,
                           input logic [15:0] got,
                           input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Drive one cycle, check busy before the edge, scoreboard after it.
  task automatic cyc(input logic        done,
                     input logic        stall,
                     input logic        br,
                     input logic [15:0] tgt,
                     input logic        e_busy,
                     input logic [15:0] e_pc,
                     input logic [15:0] e_inst,
                     input logic        e_v,
                     input logic [15:0] e_addr);
    exp_t e;
    inst_done     = done;
    id_stall      = stall;
    branch_taken  = br;
    branch_target = tgt;
    exp_q.push_back('{pc: e_pc, inst: e_inst, v: e_v, addr: e_addr});
    #1;
    check_vec("fetch_busy", {15'd0, fetch_busy}, {15'd0, e_busy});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_vec("if_id_pc", if_id_pc, e.pc);
    check_vec("if_id_inst", if_id_inst, e.inst);
    check_vec("if_id_valid", {15'd0, if_id_valid}, {15'd0, e.v});
    check_vec("inst_addr", inst_addr, e.addr);
  endtask

  task automatic chk_reset(input string tag);
    check_vec({tag, "_pc"}, if_id_pc, 16'h0000);
    check_vec({tag, "_inst"}, if_id_inst, 16'h0800);
    check_vec({tag, "_valid"}, {15'd0, if_id_valid}, 16'd0);
    check_vec({tag, "_addr"}, inst_addr, 16'h0000);
  endtask

  initial begin
    logic [15:0] a;
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    inst_done     = 1'b0;
    id_stall      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    #2;
    chk_reset("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // boot cycle: IF/ID keeps reset contents
    cyc(1, 0, 0, 0, 0, 16'h0000, 16'h0800, 0, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      a = 16'(i);
      cyc(1, 0, 0, 0, 0, a, a ^ 16'h1000, 1, a + 16'd1);
    end

    // memory wait at pc 5
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 1, 16'h0005, 16'h0800, 0, 16'h0005);
    cyc(1, 0, 0, 0, 0, 16'h0005, 16'h1005, 1, 16'h0006);

    for (int i = 6; i < 16; i++) begin
      a = 16'(i);
      cyc(1, 0, 0, 0, 0, a, a ^ 16'h1000, 1, a + 16'd1);
    end

    // stall with word at 0x10 captured, memory then idle
    cyc(1, 1, 0, 0, 0, 16'h000F, 16'h100F, 1, 16'h0010);
    cyc(0, 1, 0, 0, 0, 16'h000F, 16'h100F, 1, 16'h0010);
    cyc(0, 0, 0, 0, 0, 16'h0010, 16'h1010, 1, 16'h0011);

    // branch in S_FETCH drops the fetched word
    cyc(1, 0, 1, 16'h01C2, 0, 16'h01C2, 16'h0800, 0, 16'h01C2);
    // enter S_HELD, then branch discards the hold
    cyc(1, 1, 0, 0, 0, 16'h01C2, 16'h0800, 0, 16'h01C2);
    cyc(1, 0, 1, 16'h01C2, 0, 16'h01C2, 16'h0800, 0, 16'h01C2);
    cyc(1, 0, 0, 0, 0, 16'h01C2, 16'h11C2, 1, 16'h01C3);

    // stall without data in S_FETCH: all holds
    cyc(0, 1, 0, 0, 1, 16'h01C2, 16'h11C2, 1, 16'h01C3);

    // PC wrap
    cyc(1, 0, 1, 16'hFFFF, 0, 16'hFFFF, 16'h0800, 0, 16'hFFFF);
    cyc(1, 0, 0, 0, 0, 16'hFFFF, 16'hEFFF, 1, 16'h0000);
    cyc(1, 0, 0, 0, 0, 16'h0000, 16'h1000, 1, 16'h0001);

    // async reset while in S_HELD
    cyc(1, 1, 0, 0, 0, 16'h0000, 16'h1000, 1, 16'h0001);
    rst = 1'b1;
    #1;
    chk_reset("arst");
    #2;
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 16'h0000, 16'h0800, 0, 16'h0000);
    cyc(1, 0, 0, 0, 0, 16'h0000, 16'h1000, 1, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front end of the zhxpu 16-bit pipeline; sits directly upstream of inst_mem_ctrl and directly feeds the ID stage.
- Owns the PC and drives inst_addr to the instruction memory controller.
- Consumes inst_data/inst_done and produces the IF/ID pipeline register.
- Handles memory wait bubbles, ID-stage stalls (holding a fetched word in a one-entry buffer so memory is not re-read) and branch redirects with flush.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INST, 16'h0800, instruction word injected for bubbles and flushes

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
inst_addr  out  16  fetch address to the instruction memory controller; equals PC register
inst_data  in  16  instruction word from the memory controller; valid only when inst_done=1
inst_done  in  1  memory controller has inst_data for the current inst_addr
id_stall  in  1  hazard unit: ID cannot accept a new instruction this cycle
branch_taken  in  1  ID resolved a taken branch/jump this cycle
branch_target  in  16  redirect PC, sampled when branch_taken=1
if_id_pc  out  16  address of the instruction held in IF/ID
if_id_inst  out  16  instruction held in IF/ID
if_id_valid  out  1  IF/ID holds a real fetched instruction (0 = bubble)
fetch_busy  out  1  combinational: state==S_FETCH and inst_done=0

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, if_id_pc=16'h0000, if_id_inst=NOP_INST, if_id_valid=0, hold_inst=NOP_INST, hold_pc=0, state=S_BOOT.
- inst_addr = pc at all times; pc changes only on clock edges, so the address is stable for a full cycle.
- S_BOOT: one cycle; IF/ID keeps its reset values; go to S_FETCH. Inputs are ignored.
- S_FETCH, evaluated by priority:
  1. branch_taken=1 and id_stall=0: pc<=branch_target; IF/ID<=bubble (NOP_INST, valid 0, if_id_pc<=branch_target); any inst_data this cycle is discarded; stay.
  2. id_stall=1 and inst_done=1: hold_inst<=inst_data; hold_pc<=pc; IF/ID unchanged; pc unchanged; go to S_HELD.
  3. id_stall=1 and inst_done=0: everything holds.
  4. id_stall=0 and inst_done=1: IF/ID<={pc, inst_data, valid 1}; pc<=pc+1.
  5. id_stall=0 and inst_done=0: IF/ID<=bubble (if_id_pc<=pc); pc holds.
- S_HELD (memory is not consulted; inst_done is ignored):
  1. branch_taken=1 and id_stall=0: discard hold; pc<=branch_target; IF/ID<=bubble; go to S_FETCH.
  2. id_stall=1: stay; all registers hold.
  3. id_stall=0: IF/ID<={hold_pc, hold_inst, valid 1}; pc<=pc+1; go to S_FETCH.
- branch_taken while id_stall=1 is ignored; the hazard unit guarantees it never asserts both.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, with no flag.
- Throughput: one instruction per cycle when inst_done stays high and id_stall=0.
- Latency: inst_addr=A with inst_done=1 at edge k gives if_id_inst valid after edge k.
- rst asserted in any state, including S_HELD or mid-wait, returns immediately to reset values; a held word is lost.

Decomposition:
- Add the state encodings (S_BOOT, S_FETCH, S_HELD) and NOP_INST (16'h0800) to define.v alongside the RegValue/MemValue widths.
- Reuse existing `RegValue for all 16-bit buses.
- One sub-module is natural: if_id_reg (register with load/bubble/hold controls).
- The FSM, PC and hold buffer stay in inst_fetch_unit.

Test Plan:
- Reset then inst_done=1 constant, memory returns addr^16'h1000, id_stall=0 -> after S_BOOT, if_id_pc=0,1,2... on consecutive cycles, if_id_inst=16'h1000,16'h1001..., valid=1.
- inst_done low for 3 cycles at pc=16'h0005 -> three bubbles (inst 16'h0800, valid 0), pc stays 16'h0005, fetch_busy=1; then word at 5 loads and pc=16'h0006.
- At pc=16'h0010 with inst_done=1 and id_stall=1 for 2 cycles, inst_done then forced to 0 -> S_HELD, IF/ID unchanged; on release if_id_pc=16'h0010, correct word, valid=1, pc=16'h0011.
- branch_taken=1, target=16'h01C2, in S_FETCH with inst_done=1 -> fetched word dropped, IF/ID bubble, next inst_addr=16'h01C2; repeat while in S_HELD -> hold discarded, same result.
- pc=16'hFFFF, inst_done=1 -> if_id_pc=16'hFFFF, then inst_addr=16'h0000; rst pulsed while in S_HELD -> all outputs at reset values asynchronously, before the next edge.
